rc5_round_ctrl: RTL and testbench

- Sequences one RC5-W/R encryption block through a single shared `rotl` instance plus one adder, one half-round per cycle.
- Accepts a two-word plaintext over a valid/ready handshake and fetches expanded subkeys from an external subkey table, one word per cycle.
- Presents the ciphertext over a valid/ready handshake.
- Sits between the block-level I/O wrapper and the key-expansion table in the RC5 accelerator.

---
 rtl/rc5_round_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rc5_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_round_ctrl.sv
// RC5-W/R round sequencer: one half-round per cycle through one shared rotator.
// Optional reverse (decryption) sequencing is enabled by defining RC5_DECRYPT_EN.
module rc5_rotl #(
   parameter int W  = 16,
   parameter int LW = $clog2(W)
) (
   input  logic [W-1:0]  x_i,
   input  logic [LW-1:0] amt_i,
   output logic [W-1:0]  y_o
);

   localparam int LW1 = LW + 1;

   logic [LW:0] inv_amt;

   assign inv_amt = LW1'(W) - {1'b0, amt_i};
   assign y_o     = (x_i << amt_i) | (x_i >> inv_amt);

endmodule

module rc5_round_ctrl #(
   parameter  int W       = 16,
   parameter  int ROUNDS  = 12,
   localparam int SKEY_AW = $clog2(2*ROUNDS+2)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [W-1:0]       a_i,
   input  logic [W-1:0]       b_i,
`ifdef RC5_DECRYPT_EN
   input  logic               dec_i,
`endif
   output logic [SKEY_AW-1:0] skey_addr_o,
   input  logic [W-1:0]       skey_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [W-1:0]       a_o,
   output logic [W-1:0]       b_o,
   output logic               busy_o
);

   localparam int LW = $clog2(W);
   localparam int CW = $clog2(ROUNDS+1);

   typedef enum logic [2:0] {
      IDLE,
      PRE_A,
      PRE_B,
      HALF_A,
      HALF_B,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [CW-1:0] i_q, i_d;

   logic [W-1:0]  rot_x, rot_y;
   logic [LW-1:0] rot_amt;
   logic [W-1:0]  add_op, add_res;

`ifdef RC5_DECRYPT_EN
   logic          dec_q, dec_d;
   logic [W-1:0]  sub_op, sub_res;

   // Reverse half-rounds subtract the subkey before rotating right.
   assign sub_op  = (state_q == HALF_B || state_q == PRE_B) ? b_q : a_q;
   assign sub_res = sub_op - skey_data_i;
`endif

   always_comb begin
      skey_addr_o = '0;
      unique case (state_q)
         PRE_A:   skey_addr_o = '0;
         PRE_B:   skey_addr_o = SKEY_AW'(1);
         HALF_A:  skey_addr_o = SKEY_AW'({i_q, 1'b0});
         HALF_B:  skey_addr_o = SKEY_AW'({i_q, 1'b1});
         default: skey_addr_o = '0;
      endcase
   end

   always_comb begin
      rot_x   = a_q ^ b_q;
      rot_amt = (state_q == HALF_B) ? a_q[LW-1:0] : b_q[LW-1:0];
`ifdef RC5_DECRYPT_EN
      if (dec_q) begin
         rot_x   = sub_res;
         rot_amt = (state_q == HALF_B) ? LW'(0) - a_q[LW-1:0]
                                       : LW'(0) - b_q[LW-1:0];
      end
`endif
   end

   rc5_rotl #(
      .W  (W),
      .LW (LW)
   ) u_rotl (
      .x_i   (rot_x),
      .amt_i (rot_amt),
      .y_o   (rot_y)
   );

   always_comb begin
      add_op = rot_y;
      if (state_q == PRE_A) begin
         add_op = a_q;
      end else if (state_q == PRE_B) begin
         add_op = b_q;
      end
   end

   assign add_res = add_op + skey_data_i;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
`ifdef RC5_DECRYPT_EN
      dec_d   = dec_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               i_d     = CW'(1);
               state_d = PRE_A;
`ifdef RC5_DECRYPT_EN
               dec_d   = dec_i;
               if (dec_i) begin
                  i_d     = CW'(ROUNDS);
                  state_d = HALF_B;
               end
`endif
            end
         end
         PRE_A: begin
`ifdef RC5_DECRYPT_EN
            if (dec_q) begin
               a_d     = sub_res;
               state_d = DONE;
            end else
`endif
            begin
               a_d     = add_res;
               state_d = PRE_B;
            end
         end
         PRE_B: begin
`ifdef RC5_DECRYPT_EN
            if (dec_q) begin
               b_d     = sub_res;
               state_d = PRE_A;
            end else
`endif
            begin
               b_d     = add_res;
               state_d = HALF_A;
            end
         end
         HALF_A: begin
`ifdef RC5_DECRYPT_EN
            if (dec_q) begin
               a_d = rot_y ^ b_q;
               if (i_q == CW'(1)) begin
                  state_d = PRE_B;
               end else begin
                  i_d     = i_q - CW'(1);
                  state_d = HALF_B;
               end
            end else
`endif
            begin
               a_d     = add_res;
               state_d = HALF_B;
            end
         end
         HALF_B: begin
`ifdef RC5_DECRYPT_EN
            if (dec_q) begin
               b_d     = rot_y ^ a_q;
               state_d = HALF_A;
            end else
`endif
            begin
               b_d = add_res;
               if (i_q == CW'(ROUNDS)) begin
                  state_d = DONE;
               end else begin
                  i_d     = i_q + CW'(1);
                  state_d = HALF_A;
               end
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
`ifdef RC5_DECRYPT_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
`ifdef RC5_DECRYPT_EN
         dec_q   <= dec_d;
`endif
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = (state_q == DONE);
   assign a_o         = a_q;
   assign b_o         = b_q;

endmodule

// File: tb/tb_rc5_round_ctrl.sv
// Bench for rc5_round_ctrl: two instances (ROUNDS=2 and ROUNDS=1) on shared
// stimulus, checked every cycle against a plain-arithmetic RC5 model.
module tb_rc5_round_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] a_in, b_in;
   logic        dec;
   logic        out_ready;
   int          tbl_mode;

   logic        in_ready  [2];
   logic        out_valid [2];
   logic        busy      [2];
   logic [15:0] a_out     [2];
   logic [15:0] b_out     [2];
   logic [2:0]  addr0;
   logic [1:0]  addr1;
   logic [15:0] sk0, sk1;

   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] skey(input int mode, input int k);
      logic [15:0] v;
      if (mode == 0)      v = 16'h0000;
      else if (mode == 1) v = 16'(k);
      else                v = 16'(k * 16'h9E37 + 16'h5163);
      return v;
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] x, input int r);
      int s;
      s = r % 16;
      return (x << s) | (x >> (16 - s));
   endfunction

   function automatic logic [31:0] enc(input logic [15:0] a0, input logic [15:0] b0,
                                       input int r, input int mode);
      logic [15:0] a, b;
      a = a0 + skey(mode, 0);
      b = b0 + skey(mode, 1);
      for (int i = 1; i <= r; i++) begin
         a = rotl16(a ^ b, int'(b) % 16) + skey(mode, 2*i);
         b = rotl16(b ^ a, int'(a) % 16) + skey(mode, 2*i+1);
      end
      return {a, b};
   endfunction

   function automatic logic [31:0] decr(input logic [15:0] a0, input logic [15:0] b0,
                                        input int r, input int mode);
      logic [15:0] a, b;
      a = a0;
      b = b0;
      for (int i = r; i >= 1; i--) begin
         b = rotl16(b - skey(mode, 2*i+1), (16 - int'(a) % 16) % 16) ^ a;
         a = rotl16(a - skey(mode, 2*i), (16 - int'(b) % 16) % 16) ^ b;
      end
      b = b - skey(mode, 1);
      a = a - skey(mode, 0);
      return {a, b};
   endfunction

   assign sk0 = skey(tbl_mode, int'(addr0));
   assign sk1 = skey(tbl_mode, int'(addr1));

   rc5_round_ctrl #(.W(16), .ROUNDS(2)) u_r2 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready[0]),
      .a_i         (a_in),
      .b_i         (b_in),
`ifdef RC5_DECRYPT_EN
      .dec_i       (dec),
`endif
      .skey_addr_o (addr0),
      .skey_data_i (sk0),
      .out_valid_o (out_valid[0]),
      .out_ready_i (out_ready),
      .a_o         (a_out[0]),
      .b_o         (b_out[0]),
      .busy_o      (busy[0])
   );

   rc5_round_ctrl #(.W(16), .ROUNDS(1)) u_r1 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready[1]),
      .a_i         (a_in),
      .b_i         (b_in),
`ifdef RC5_DECRYPT_EN
      .dec_i       (dec),
`endif
      .skey_addr_o (addr1),
      .skey_data_i (sk1),
      .out_valid_o (out_valid[1]),
      .out_ready_i (out_ready),
      .a_o         (a_out[1]),
      .b_o         (b_out[1]),
      .busy_o      (busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, got, exp, $time);
      end
   endtask

   // Model: a block is in flight for 2R+2 cycles, then waits in DONE.
   bit          act [2];
   int          t   [2];
   bit          dm  [2];
   logic [15:0] ea  [2];
   logic [15:0] eb  [2];

   function automatic int rnds(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            act[d] <= 1'b0;
            t[d]   <= 0;
         end else if (!act[d]) begin
            if (in_valid) begin
               act[d] <= 1'b1;
               t[d]   <= 0;
               dm[d]  <= dec;
               if (dec) {ea[d], eb[d]} <= decr(a_in, b_in, rnds(d), tbl_mode);
               else     {ea[d], eb[d]} <= enc(a_in, b_in, rnds(d), tbl_mode);
            end
         end else if (t[d] == 2*rnds(d)+2) begin
            if (out_ready) act[d] <= 1'b0;
         end else begin
            t[d] <= t[d] + 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         automatic int  r  = rnds(d);
         automatic bit  ov = act[d] && (t[d] == 2*r+2);
         automatic int  ex = 0;
         automatic int  ga = (d == 0) ? int'(addr0) : int'(addr1);
         if (act[d] && t[d] <= 2*r+1) ex = dm[d] ? (2*r+1 - t[d]) : t[d];
         chk("in_ready", d, 32'(in_ready[d]), 32'(!act[d]));
         chk("busy", d, 32'(busy[d]), 32'(act[d]));
         chk("out_valid", d, 32'(out_valid[d]), 32'(ov));
         chk("skey_addr", d, 32'(ga), 32'(ex));
         if (ov) chk("result", d, {a_out[d], b_out[d]}, {ea[d], eb[d]});
         if (!rst_n) chk("reset_ab", d, {a_out[d], b_out[d]}, 32'h0);
      end
   end

   logic [1:0] aseq1 [4];

   task automatic handshake(input logic [15:0] a, input logic [15:0] b, input bit d);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      dec      = d;
      @(posedge clk);
      #1;
      // Keep in_valid high with junk data while both instances are busy.
      a_in = 16'hDEAD;
      b_in = 16'hBEEF;
   endtask

   task automatic run(output logic [31:0] r0, output logic [31:0] r1,
                      output int l0, output int l1);
      bit s0, s1;
      s0 = 0; s1 = 0; l0 = -1; l1 = -1; r0 = '0; r1 = '0;
      for (int n = 0; n < 40 && !(s0 && s1); n++) begin
         @(negedge clk);
         if (n == 0) in_valid = 1'b0;
         if (n < 4) aseq1[n] = addr1;
         if (!s0 && out_valid[0]) begin
            s0 = 1; l0 = n; r0 = {a_out[0], b_out[0]};
         end
         if (!s1 && out_valid[1]) begin
            s1 = 1; l1 = n; r1 = {a_out[1], b_out[1]};
         end
      end
      if (!(s0 && s1)) chk("timeout", 0, 32'({s0, s1}), 32'h3);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
   endtask

   logic [31:0] r0, r1;
   int          l0, l1;
   logic [15:0] va [3] = '{16'h1234, 16'hFFFF, 16'h8000};
   logic [15:0] vb [3] = '{16'h5678, 16'h0001, 16'h7FFF};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
      dec = 1'b0; out_ready = 1'b1; tbl_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", d, 32'(in_ready[d]), 32'h1);
         chk("rst_busy", d, 32'(busy[d]), 32'h0);
      end
      #2 rst_n = 1'b1;

      tbl_mode = 0;
      handshake(16'h0001, 16'h0000, 1'b0);
      run(r0, r1, l0, l1);
      chk("t1_r2", 0, r0, 32'h000C_E000);
      chk("t1_lat_r2", 0, 32'(l0), 32'd6);
      chk("t1_lat_r1", 1, 32'(l1), 32'd4);
      settle();

      handshake(16'h0000, 16'h0013, 1'b0);
      run(r0, r1, l0, l1);
      chk("t2_mask_r1", 1, r1, 32'h0098_8B00);
      settle();

      tbl_mode = 1;
      handshake(16'h0000, 16'h0000, 1'b0);
      run(r0, r1, l0, l1);
      chk("t3_r1", 1, r1, 32'h0004_0053);
      for (int k = 0; k < 4; k++) chk("t3_addr_seq", 1, 32'(aseq1[k]), 32'(k));
      settle();

      tbl_mode = 2;
      for (int v = 0; v < 3; v++) begin
         handshake(va[v], vb[v], 1'b0);
         run(r0, r1, l0, l1);
         settle();
      end

      tbl_mode = 0;
      out_ready = 1'b0;
      handshake(16'h0001, 16'h0000, 1'b0);
      run(r0, r1, l0, l1);
      chk("bp_r2", 0, r0, 32'h000C_E000);
      chk("bp_r1", 1, r1, 32'h0001_0002);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_r2", 0, {a_out[0], b_out[0]}, 32'h000C_E000);
         chk("bp_hold_r1", 1, {a_out[1], b_out[1]}, 32'h0001_0002);
         for (int d = 0; d < 2; d++) begin
            chk("bp_in_ready", d, 32'(in_ready[d]), 32'h0);
            chk("bp_busy", d, 32'(busy[d]), 32'h1);
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("bp_release_ready", d, 32'(in_ready[d]), 32'h1);
         chk("bp_release_valid", d, 32'(out_valid[d]), 32'h0);
      end
      settle();

      tbl_mode = 2;
      handshake(16'hA5A5, 16'h5A5A, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("mid_rst_valid", d, 32'(out_valid[d]), 32'h0);
         chk("mid_rst_busy", d, 32'(busy[d]), 32'h0);
         chk("mid_rst_ab", d, {a_out[d], b_out[d]}, 32'h0);
      end
      chk("mid_rst_addr", 0, 32'(addr0), 32'h0);
      chk("mid_rst_addr", 1, 32'(addr1), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tbl_mode = 0;
      handshake(16'h0001, 16'h0000, 1'b0);
      run(r0, r1, l0, l1);
      chk("post_rst_r2", 0, r0, 32'h000C_E000);
      settle();

`ifdef RC5_DECRYPT_EN
      handshake(16'h000C, 16'hE000, 1'b1);
      run(r0, r1, l0, l1);
      chk("dec_r2", 0, r0, 32'h0001_0000);
      chk("dec_lat_r2", 0, 32'(l0), 32'd6);
      settle();
      tbl_mode = 2;
      handshake(16'h3C3C, 16'h0F0F, 1'b1);
      run(r0, r1, l0, l1);
      settle();
      dec = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
